// File: rtl/fft_butterfly_writeback.sv
// Radix-2 butterfly write-back stage: pairs A/B beats with a twiddle, computes
// X=A+W*B and Y=A-W*B, and writes both results back in place.
module fft_butterfly_writeback #(
   parameter int N        = 16,
   parameter int SIZE     = 4,
   parameter int WIDTH    = 16,
   parameter int TW_WIDTH = 16,
   parameter int SCALE    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_stage,
   input  logic                       in_valid,
   input  logic [SIZE-1:0]            in_addr,
   input  logic signed [WIDTH-1:0]    in_re,
   input  logic signed [WIDTH-1:0]    in_im,
   input  logic signed [TW_WIDTH-1:0] tw_re,
   input  logic signed [TW_WIDTH-1:0] tw_im,
   output logic                       wr_en,
   output logic [SIZE-1:0]            wr_addr,
   output logic [WIDTH-1:0]           wr_re,
   output logic [WIDTH-1:0]           wr_im,
   output logic                       busy,
   output logic                       stage_done
);

   typedef enum logic [2:0] {IDLE, CAP_A, CAP_B, DRAIN, DONE} state_t;

   localparam int PW = WIDTH + TW_WIDTH + 1;
   localparam int RW = WIDTH + 1;
   localparam int SW = WIDTH + 2;
   localparam logic [SIZE-1:0]        LAST_PAIR = SIZE'(N / 2 - 1);
   localparam logic signed [SW-1:0]   SAT_MAX   = SW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [SW-1:0]   SAT_MIN   = ~SAT_MAX;

   state_t                     state_q, state_d;
   logic [SIZE-1:0]            pair_cnt_q, pair_cnt_d;
   logic signed [WIDTH-1:0]    a_re_q, a_re_d, a_im_q, a_im_d;
   logic signed [TW_WIDTH-1:0] w_re_q, w_re_d, w_im_q, w_im_d;
   logic [SIZE-1:0]            addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic                       s1_valid_q, s1_valid_d;
   logic signed [RW-1:0]       p_re_q, p_re_d, p_im_q, p_im_d;
   logic                       y_pend_q, y_pend_d;
   logic [WIDTH-1:0]           y_re_q, y_re_d, y_im_q, y_im_d;
   logic                       wr_en_q, wr_en_d;
   logic [SIZE-1:0]            wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]           wr_re_q, wr_re_d, wr_im_q, wr_im_d;
   logic                       cap_a, cap_b, flush;
   logic signed [PW-1:0]       prod_re, prod_im;
   logic signed [SW-1:0]       sum_re, sum_im, dif_re, dif_im;

   function automatic logic [WIDTH-1:0] fit(input logic signed [SW-1:0] v);
      if (SCALE != 0) return WIDTH'(v >>> 1);
      if (v > SAT_MAX) return WIDTH'(SAT_MAX);
      if (v < SAT_MIN) return WIDTH'(SAT_MIN);
      return WIDTH'(v);
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      pair_cnt_d = pair_cnt_q;
      cap_a      = 1'b0;
      cap_b      = 1'b0;
      flush      = 1'b0;
      if (start_stage) begin
         state_d    = CAP_A;
         pair_cnt_d = '0;
         flush      = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: ;
            CAP_A: if (in_valid) begin
               cap_a   = 1'b1;
               state_d = CAP_B;
            end
            CAP_B: if (in_valid) begin
               cap_b      = 1'b1;
               pair_cnt_d = pair_cnt_q + 1'b1;
               state_d    = (pair_cnt_q == LAST_PAIR) ? DRAIN : CAP_A;
            end
            DRAIN: if (wr_en_q && !y_pend_q && !s1_valid_q) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // A, its address and B's address are read one cycle after capture; the next
   // pair can overwrite them no earlier than that, so no extra pipeline copy.
   always_comb begin
      prod_re = PW'(in_re) * PW'(w_re_q) - PW'(in_im) * PW'(w_im_q);
      prod_im = PW'(in_re) * PW'(w_im_q) + PW'(in_im) * PW'(w_re_q);
      sum_re  = SW'(a_re_q) + SW'(p_re_q);
      sum_im  = SW'(a_im_q) + SW'(p_im_q);
      dif_re  = SW'(a_re_q) - SW'(p_re_q);
      dif_im  = SW'(a_im_q) - SW'(p_im_q);
   end

   always_comb begin
      a_re_d     = a_re_q;
      a_im_d     = a_im_q;
      w_re_d     = w_re_q;
      w_im_d     = w_im_q;
      addr_a_d   = addr_a_q;
      addr_b_d   = addr_b_q;
      p_re_d     = p_re_q;
      p_im_d     = p_im_q;
      y_re_d     = y_re_q;
      y_im_d     = y_im_q;
      wr_addr_d  = wr_addr_q;
      wr_re_d    = wr_re_q;
      wr_im_d    = wr_im_q;
      s1_valid_d = cap_b;
      y_pend_d   = s1_valid_q && !flush;
      wr_en_d    = (s1_valid_q || y_pend_q) && !flush;
      if (cap_a) begin
         a_re_d   = in_re;
         a_im_d   = in_im;
         w_re_d   = tw_re;
         w_im_d   = tw_im;
         addr_a_d = in_addr;
      end
      if (cap_b) begin
         addr_b_d = in_addr;
         p_re_d   = RW'(prod_re >>> (TW_WIDTH - 1));
         p_im_d   = RW'(prod_im >>> (TW_WIDTH - 1));
      end
      if (s1_valid_q) begin
         y_re_d    = fit(dif_re);
         y_im_d    = fit(dif_im);
         wr_addr_d = addr_a_q;
         wr_re_d   = fit(sum_re);
         wr_im_d   = fit(sum_im);
      end else if (y_pend_q) begin
         wr_addr_d = addr_b_q;
         wr_re_d   = y_re_q;
         wr_im_d   = y_im_q;
      end
      if (flush) begin
         a_re_d    = '0;
         a_im_d    = '0;
         w_re_d    = '0;
         w_im_d    = '0;
         addr_a_d  = '0;
         addr_b_d  = '0;
         p_re_d    = '0;
         p_im_d    = '0;
         y_re_d    = '0;
         y_im_d    = '0;
         wr_addr_d = '0;
         wr_re_d   = '0;
         wr_im_d   = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pair_cnt_q <= '0;
         a_re_q     <= '0;
         a_im_q     <= '0;
         w_re_q     <= '0;
         w_im_q     <= '0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         s1_valid_q <= 1'b0;
         p_re_q     <= '0;
         p_im_q     <= '0;
         y_pend_q   <= 1'b0;
         y_re_q     <= '0;
         y_im_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_re_q    <= '0;
         wr_im_q    <= '0;
      end else begin
         state_q    <= state_d;
         pair_cnt_q <= pair_cnt_d;
         a_re_q     <= a_re_d;
         a_im_q     <= a_im_d;
         w_re_q     <= w_re_d;
         w_im_q     <= w_im_d;
         addr_a_q   <= addr_a_d;
         addr_b_q   <= addr_b_d;
         s1_valid_q <= s1_valid_d;
         p_re_q     <= p_re_d;
         p_im_q     <= p_im_d;
         y_pend_q   <= y_pend_d;
         y_re_q     <= y_re_d;
         y_im_q     <= y_im_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_re_q    <= wr_re_d;
         wr_im_q    <= wr_im_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_re      = wr_re_q;
   assign wr_im      = wr_im_q;
   assign busy       = (state_q != IDLE);
   assign stage_done = (state_q == DONE);

endmodule

// File: tb/tb_fft_butterfly_writeback.sv
// Bench for fft_butterfly_writeback: a SCALE=0 and a SCALE=1 instance share
// stimulus; a cycle-stamped queue of expected writes is checked every cycle.
module tb_fft_butterfly_writeback;

   typedef struct {
      int          cyc;
      logic [3:0]  addr;
      logic [15:0] re0, im0, re1, im1;
   } wr_t;

   logic        clk = 1'b0, rst_n = 1'b0, start_stage = 1'b0, in_valid = 1'b0;
   logic [3:0]  in_addr = '0;
   logic [15:0] in_re = '0, in_im = '0, tw_re = '0, tw_im = '0;
   logic [1:0]  wr_en, busy, stage_done;
   logic [3:0]  wr_addr0, wr_addr1;
   logic [15:0] wr_re0, wr_im0, wr_re1, wr_im1;

   int  total = 0, bad = 0, cyc = 0;
   wr_t exp_q[$];

   fft_butterfly_writeback #(.N(16), .SIZE(4), .WIDTH(16), .TW_WIDTH(16), .SCALE(0)) dut_s0 (
      .clk(clk), .rst_n(rst_n), .start_stage(start_stage), .in_valid(in_valid),
      .in_addr(in_addr), .in_re(in_re), .in_im(in_im), .tw_re(tw_re), .tw_im(tw_im),
      .wr_en(wr_en[0]), .wr_addr(wr_addr0), .wr_re(wr_re0), .wr_im(wr_im0),
      .busy(busy[0]), .stage_done(stage_done[0]));

   fft_butterfly_writeback #(.N(16), .SIZE(4), .WIDTH(16), .TW_WIDTH(16), .SCALE(1)) dut_s1 (
      .clk(clk), .rst_n(rst_n), .start_stage(start_stage), .in_valid(in_valid),
      .in_addr(in_addr), .in_re(in_re), .in_im(in_im), .tw_re(tw_re), .tw_im(tw_im),
      .wr_en(wr_en[1]), .wr_addr(wr_addr1), .wr_re(wr_re1), .wr_im(wr_im1),
      .busy(busy[1]), .stage_done(stage_done[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic longint sx(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   // scaled twiddle product, floor-divided by 2^15 and kept to 17 signed bits
   function automatic longint wprod(input longint p);
      logic signed [16:0] lo;
      longint q;
      q  = p >>> 15;
      lo = q[16:0];
      return longint'(lo);
   endfunction

   function automatic logic [15:0] fit(input longint s, input bit scale);
      longint h;
      if (scale) begin
         h = s >>> 1;
         return h[15:0];
      end
      if (s > 32767) return 16'h7fff;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 4))
         0:       return 16'h7fff;
         1:       return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push(input int c, input logic [3:0] a, input logic [15:0] r0, i0, r1, i1);
      wr_t e;
      e.cyc = c; e.addr = a; e.re0 = r0; e.im0 = i0; e.re1 = r1; e.im1 = i1;
      exp_q.push_back(e);
   endtask

   task automatic beat(input logic [3:0] a, input logic [15:0] re, im, wr, wi, output int t);
      in_valid = 1'b1; in_addr = a; in_re = re; in_im = im; tw_re = wr; tw_im = wi;
      t = cyc;
      tick();
      in_valid = 1'b0; in_addr = 4'($urandom); in_re = 16'($urandom); in_im = 16'($urandom);
      tw_re = 16'($urandom); tw_im = 16'($urandom);
   endtask

   // A beat, optional gap, B beat with junk twiddle (twiddle belongs to the A beat)
   task automatic send(input logic [3:0] aa, ab, input logic [15:0] ar, ai, br, bi, wr, wi,
                       input int gap, output int tb);
      int ta;
      beat(aa, ar, ai, wr, wi, ta);
      repeat (gap) tick();
      beat(ab, br, bi, 16'($urandom), 16'($urandom), tb);
   endtask

   task automatic pair_model(input int gap, output int tb);
      logic [3:0]  aa, ab;
      logic [15:0] ar, ai, br, bi, wr, wi;
      longint      pr, pi;
      aa = 4'($urandom); ab = 4'($urandom);
      ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16(); wr = rnd16(); wi = rnd16();
      send(aa, ab, ar, ai, br, bi, wr, wi, gap, tb);
      pr = wprod(sx(br) * sx(wr) - sx(bi) * sx(wi));
      pi = wprod(sx(br) * sx(wi) + sx(bi) * sx(wr));
      push(tb + 2, aa, fit(sx(ar) + pr, 0), fit(sx(ai) + pi, 0), fit(sx(ar) + pr, 1), fit(sx(ai) + pi, 1));
      push(tb + 3, ab, fit(sx(ar) - pr, 0), fit(sx(ai) - pi, 0), fit(sx(ar) - pr, 1), fit(sx(ai) - pi, 1));
   endtask

   task automatic arm(input string tag);
      start_stage = 1'b1;
      tick();
      start_stage = 1'b0;
      total++;
      if (busy !== 2'b11) begin
         bad++;
         $display("FAIL %s arm: busy=%b want 11", tag, busy);
      end
   endtask

   // last B beat at tb: Y written at tb+3, stage_done at tb+4, idle at tb+5
   task automatic check_done(input int tb, input string tag);
      goto(tb + 4);
      total++;
      if ({stage_done, busy} !== 4'b1111) begin
         bad++;
         $display("FAIL %s done: stage_done=%b busy=%b want 11 11", tag, stage_done, busy);
      end
      tick();
      total++;
      if ({stage_done, busy} !== 4'b0000) begin
         bad++;
         $display("FAIL %s idle: stage_done=%b busy=%b want 00 00", tag, stage_done, busy);
      end
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            total++;
            if (e.cyc != cyc || {wr_en, wr_addr0, wr_addr1, wr_re0, wr_im0, wr_re1, wr_im1} !==
                {2'b11, e.addr, e.addr, e.re0, e.im0, e.re1, e.im1}) begin
               bad++;
               $display("FAIL write cyc %0d: got en=%b addr=%0d/%0d s0=%h,%h s1=%h,%h want cyc %0d addr=%0d s0=%h,%h s1=%h,%h",
                        cyc, wr_en, wr_addr0, wr_addr1, wr_re0, wr_im0, wr_re1, wr_im1,
                        e.cyc, e.addr, e.re0, e.im0, e.re1, e.im1);
            end
         end else if (wr_en !== 2'b00) begin
            total++;
            bad++;
            $display("FAIL stray write cyc %0d: en=%b addr=%0d want no write", cyc, wr_en, wr_addr0);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      total++;
      if ({wr_en, busy, stage_done, wr_addr0, wr_addr1, wr_re0, wr_im0, wr_re1, wr_im1} !== '0) begin
         bad++;
         $display("FAIL reset outputs: en=%b busy=%b done=%b addr=%0d re=%h want all 0",
                  wr_en, busy, stage_done, wr_addr0, wr_re0);
      end
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1;
      repeat (4) begin
         in_addr = 4'($urandom); in_re = 16'($urandom); in_im = 16'($urandom);
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      total++;
      if (busy !== 2'b00) begin
         bad++;
         $display("FAIL idle ignores in_valid: busy=%b want 00", busy);
      end
   endtask

   task automatic test_spec_vectors();
      int tb;
      arm("spec");
      send(4'd3, 4'd11, 16'd100, 16'd0, 16'd50, 16'd0, 16'h7fff, 16'h0000, 0, tb);
      push(tb + 2, 4'd3,  16'd149, 16'd0, 16'd74, 16'd0);
      push(tb + 3, 4'd11, 16'd51,  16'd0, 16'd25, 16'd0);
      send(4'd5, 4'd13, 16'd100, 16'd0, 16'd50, 16'd0, 16'h0000, 16'h8000, 0, tb);
      push(tb + 2, 4'd5,  16'd100, 16'hffce, 16'd50, 16'hffe7);
      push(tb + 3, 4'd13, 16'd100, 16'd50,   16'd50, 16'd25);
      send(4'd0, 4'd8, 16'h7fff, 16'd0, 16'h7fff, 16'd0, 16'h7fff, 16'h0000, 0, tb);
      push(tb + 2, 4'd0, 16'h7fff, 16'd0, 16'h7ffe, 16'd0);
      push(tb + 3, 4'd8, 16'd1,    16'd0, 16'd0,    16'd0);
      repeat (5) pair_model(0, tb);
      check_done(tb, "spec");
   endtask

   task automatic test_back_to_back();
      int tb;
      arm("b2b");
      repeat (8) pair_model(0, tb);
      in_valid = 1'b1;
      check_done(tb, "b2b");
      repeat (4) begin
         in_addr = 4'($urandom); in_re = 16'($urandom);
         tick();
      end
      in_valid = 1'b0;
      total++;
      if (busy !== 2'b00) begin
         bad++;
         $display("FAIL b2b late in_valid: busy=%b want 00", busy);
      end
   endtask

   task automatic test_random_gaps();
      int tb;
      repeat (2) begin
         arm("gaps");
         for (int i = 0; i < 8; i++) begin
            pair_model($urandom_range(0, 2), tb);
            if (i < 7) repeat ($urandom_range(0, 2)) tick();
         end
         check_done(tb, "gaps");
      end
   endtask

   task automatic test_flush_reset();
      int tb, ta;
      arm("flush");
      repeat (3) pair_model(0, tb);
      start_stage = 1'b1;
      in_valid    = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      tick();
      start_stage = 1'b0;
      in_valid    = 1'b0;
      total++;
      if (busy !== 2'b11) begin
         bad++;
         $display("FAIL flush rearm: busy=%b want 11", busy);
      end
      repeat (8) pair_model(0, tb);
      check_done(tb, "flush");

      arm("rst");
      pair_model(0, tb);
      beat(4'($urandom), rnd16(), rnd16(), rnd16(), rnd16(), ta);
      rst_n = 1'b0;
      while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
      #1;
      total++;
      if ({wr_en, busy, stage_done, wr_addr0, wr_re0, wr_im0, wr_re1, wr_im1} !== '0) begin
         bad++;
         $display("FAIL mid reset outputs: en=%b busy=%b done=%b addr=%0d want all 0",
                  wr_en, busy, stage_done, wr_addr0);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      total++;
      if (busy !== 2'b00) begin
         bad++;
         $display("FAIL after reset: busy=%b want 00", busy);
      end
      arm("post_rst");
      repeat (8) pair_model(0, tb);
      check_done(tb, "post_rst");
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_spec_vectors();
      test_back_to_back();
      test_random_gaps();
      test_flush_reset();
      repeat (6) tick();
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL pending writes: got %0d outstanding want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
